// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM encodings, stream framing constants and the address helper.
package imem_loader_defs;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int LEN_BYTES         = 4;
    localparam int DEFAULT_MAX_WORDS = 1024;

    // Byte address of word k relative to a word-aligned base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] k);
        return base + {k[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, we, wa, wd
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, we, wa, wd
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; the word output is
// valid together with the fourth byte, so no extra cycle is spent.
module word_assembler
    import imem_loader_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);
    localparam int BW = $clog2(LEN_BYTES);

    logic [BW-1:0] b_reg;
    logic [23:0]   shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg     <= '0;
            shift_reg <= '0;
        end else if (accept) begin
            b_reg     <= b_reg + BW'(1);
            shift_reg <= {byte_in, shift_reg[23:8]};
        end
    end

    assign word = {byte_in, shift_reg};
    assign last = (b_reg == BW'(LEN_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian image into instruction memory and
// holds the CPU in reset until the final word has been written.
module imem_loader
    import imem_loader_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          err
);
    localparam int KW = $clog2(MAX_WORDS + 1);

    state_t         state_reg, state_next;
    logic [31:0]    n_reg, n_next;
    logic [KW-1:0]  k_reg, k_next;
    logic           we_reg, we_next;
    logic [31:0]    wa_reg, wa_next;
    logic [31:0]    wd_reg, wd_next;
    logic           rx_ready;
    logic           accept;
    logic [31:0]    asm_word;
    logic           asm_last;

    assign accept = bus.rx_valid && rx_ready;

    word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept),
        .byte_in (bus.rx_data),
        .word    (asm_word),
        .last    (asm_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_LEN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg  <= '0;
            k_reg  <= '0;
            we_reg <= 1'b0;
            wa_reg <= BASE_ADDR;
            wd_reg <= '0;
        end else begin
            n_reg  <= n_next;
            k_reg  <= k_next;
            we_reg <= we_next;
            wa_reg <= wa_next;
            wd_reg <= wd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        k_next     = k_reg;
        we_next    = 1'b0;
        wa_next    = wa_reg;
        wd_next    = wd_reg;
        rx_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst_n  = 1'b0;

        unique case (state_reg)
            S_LEN: begin
                rx_ready = 1'b1;
                if (accept && asm_last) begin
                    n_next = asm_word;
                    k_next = '0;
                    if (asm_word == 32'd0)
                        state_next = S_DONE;
                    else if (asm_word > 32'(MAX_WORDS))
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (accept && asm_last) begin
                    we_next = 1'b1;
                    wd_next = asm_word;
                    wa_next = word_addr(BASE_ADDR, 32'(k_reg));
                    k_next  = k_reg + KW'(1);
                    // k stays below MAX_WORDS, so the 32-bit compare cannot wrap.
                    if (32'(k_reg) + 32'd1 == n_reg)
                        state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_next = S_LEN;
            end
        endcase
    end

    assign bus.rx_ready = rx_ready;
    assign bus.we       = we_reg;
    assign bus.wa       = wa_reg;
    assign bus.wd       = wd_reg;
endmodule
